decode_stage: RTL and testbench

Registered RV32I instruction-decode pipeline stage, the successor to the combinational controller decoder. It adds a full-instruction input, immediate generation, optional M-extension decode, valid/ready handshaking, flush, load-use hazard bubbling, and a stall counter. It sits between the fetch stage and the execute stage.

---
 rtl/decode_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I (+ optional RV32M) decode between fetch and execute.
// The fetched word is decoded combinationally, then captured under valid/ready flow control.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int EN_MEXT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_regWR,
  output logic             out_memWR,
  output logic             out_aluS1,
  output logic             out_aluS2,
  output logic             out_doBranch,
  output logic             out_doJump,
  output logic             out_illegal,
  output logic [1:0]       out_wbCtrl,
  output logic [4:0]       out_aluOp,
  output logic [2:0]       out_branchCtrl,
  output logic [2:0]       out_memCtrl,
  output logic [CNT_W-1:0] hazard_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_PASSB = 5'd10;

  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] immI, immS, immB, immU, immJ;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign immI = {{20{in_instr[31]}}, in_instr[31:20]};
  assign immS = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign immB = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign immU = {in_instr[31:12], 12'b0};
  assign immJ = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  logic        decRegWR, decMemWR, decAluS1, decAluS2, decBranch, decJump, decIllegal;
  logic        usesRs1, usesRs2, hazard, advance;
  logic [1:0]  decWb;
  logic [4:0]  decAluOp, baseOp;
  logic [2:0]  decBrCtrl, decMemCtrl;
  logic [31:0] decImm;

  always_comb begin
    baseOp = ALU_ADD;
    case (funct3)
      3'b000:  baseOp = ALU_ADD;
      3'b001:  baseOp = ALU_SLL;
      3'b010:  baseOp = ALU_SLT;
      3'b011:  baseOp = ALU_SLTU;
      3'b100:  baseOp = ALU_XOR;
      3'b101:  baseOp = ALU_SRL;
      3'b110:  baseOp = ALU_OR;
      default: baseOp = ALU_AND;
    endcase
  end

  // Field decode; illegal encodings keep their fields but lose every side effect.
  always_comb begin
    decRegWR   = 1'b0;
    decMemWR   = 1'b0;
    decAluS1   = 1'b0;
    decAluS2   = 1'b0;
    decBranch  = 1'b0;
    decJump    = 1'b0;
    decIllegal = 1'b0;
    usesRs1    = 1'b0;
    usesRs2    = 1'b0;
    decWb      = WB_ALU;
    decAluOp   = ALU_ADD;
    decBrCtrl  = 3'b000;
    decMemCtrl = 3'b000;
    decImm     = 32'd0;
    case (opcode)
      OP_R: begin
        decRegWR = 1'b1;
        usesRs1  = 1'b1;
        usesRs2  = 1'b1;
        if (funct7 == 7'b0000000)
          decAluOp = baseOp;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000)
          decAluOp = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101)
          decAluOp = ALU_SRA;
        else if (funct7 == 7'b0000001 && EN_MEXT != 0)
          decAluOp = {2'b10, funct3};
        else
          decIllegal = 1'b1;
      end
      OP_IMM: begin
        decRegWR = 1'b1;
        decAluS2 = 1'b1;
        usesRs1  = 1'b1;
        decImm   = immI;
        decAluOp = (funct3 == 3'b101 && funct7 == 7'b0100000) ? ALU_SRA : baseOp;
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          decIllegal = 1'b1;
      end
      OP_LOAD: begin
        decRegWR   = 1'b1;
        decAluS2   = 1'b1;
        usesRs1    = 1'b1;
        decWb      = WB_MEM;
        decImm     = immI;
        decMemCtrl = funct3;
        decIllegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        decMemWR   = 1'b1;
        decAluS2   = 1'b1;
        usesRs1    = 1'b1;
        usesRs2    = 1'b1;
        decImm     = immS;
        decMemCtrl = funct3;
        decIllegal = (funct3 >= 3'b011);
      end
      OP_BRANCH: begin
        decBranch  = 1'b1;
        decAluS1   = 1'b1;
        decAluS2   = 1'b1;
        usesRs1    = 1'b1;
        usesRs2    = 1'b1;
        decImm     = immB;
        decBrCtrl  = funct3;
        decIllegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LUI: begin
        decRegWR = 1'b1;
        decAluS2 = 1'b1;
        decAluOp = ALU_PASSB;
        decImm   = immU;
      end
      OP_AUIPC: begin
        decRegWR = 1'b1;
        decAluS1 = 1'b1;
        decAluS2 = 1'b1;
        decImm   = immU;
      end
      OP_JAL: begin
        decRegWR = 1'b1;
        decJump  = 1'b1;
        decAluS1 = 1'b1;
        decAluS2 = 1'b1;
        decWb    = WB_PC4;
        decImm   = immJ;
      end
      OP_JALR: begin
        decRegWR   = 1'b1;
        decJump    = 1'b1;
        decAluS2   = 1'b1;
        usesRs1    = 1'b1;
        decWb      = WB_PC4;
        decImm     = immI;
        decIllegal = (funct3 != 3'b000);
      end
      default: decIllegal = 1'b1;
    endcase
    if (decIllegal) begin
      decRegWR  = 1'b0;
      decMemWR  = 1'b0;
      decBranch = 1'b0;
      decJump   = 1'b0;
    end
  end

  assign hazard  = in_valid && ex_load && (ex_rd != 5'd0) &&
                   ((usesRs1 && rs1 == ex_rd) || (usesRs2 && rs2 == ex_rd));
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;

  // Flush outranks everything but reset; a stalled advance becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_rd         <= '0;
      out_imm        <= '0;
      out_regWR      <= 1'b0;
      out_memWR      <= 1'b0;
      out_aluS1      <= 1'b0;
      out_aluS2      <= 1'b0;
      out_doBranch   <= 1'b0;
      out_doJump     <= 1'b0;
      out_illegal    <= 1'b0;
      out_wbCtrl     <= '0;
      out_aluOp      <= '0;
      out_branchCtrl <= '0;
      out_memCtrl    <= '0;
      hazard_cnt     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      if (hazard && hazard_cnt != {CNT_W{1'b1}})
        hazard_cnt <= hazard_cnt + CNT_W'(1);
      if (in_valid && in_ready) begin
        out_valid      <= 1'b1;
        out_pc         <= in_pc;
        out_rs1        <= rs1;
        out_rs2        <= rs2;
        out_rd         <= rd;
        out_imm        <= XLEN'($signed(decImm));
        out_regWR      <= decRegWR;
        out_memWR      <= decMemWR;
        out_aluS1      <= decAluS1;
        out_aluS2      <= decAluS2;
        out_doBranch   <= decBranch;
        out_doJump     <= decJump;
        out_illegal    <= decIllegal;
        out_wbCtrl     <= decWb;
        out_aluOp      <= decAluOp;
        out_branchCtrl <= decBrCtrl;
        out_memCtrl    <= decMemCtrl;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives one RV32I-only and one RV32IM decode_stage with shared stimulus
// and checks both against an instruction-level reference model plus fixed vectors.
module tb_decode_stage;

  localparam int CW = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        regWR, memWR, aluS1, aluS2, doBranch, doJump, illegal;
    logic [1:0]  wbCtrl;
    logic [4:0]  aluOp;
    logic [2:0]  branchCtrl, memCtrl;
  } dec_t;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] cnt;
    dec_t          d;
  } outs_t;

  // instr, imm, aluOp, regWR, memWR, aluS1, aluS2, doBranch, doJump, wbCtrl, memCtrl, branchCtrl, illA, illM
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  aluOp;
    logic        regWR, memWR, s1, s2, br, jmp;
    logic [1:0]  wb;
    logic [2:0]  mc, bc;
    logic        illA, illM;
  } vec_t;

  logic clk = 1'b0;
  logic rst, in_valid, flush, ex_load, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  ex_rd;

  logic readyA, vA, regWRA, memWRA, s1A, s2A, brA, jA, illA;
  logic [31:0] pcA, immA;
  logic [4:0]  rs1A, rs2A, rdA, aluA;
  logic [1:0]  wbA;
  logic [2:0]  bcA, mcA;
  logic [CW-1:0] cntA;

  logic readyM, vM, regWRM, memWRM, s1M, s2M, brM, jM, illM;
  logic [31:0] pcM, immM;
  logic [4:0]  rs1M, rs2M, rdM, aluM;
  logic [1:0]  wbM;
  logic [2:0]  bcM, mcM;
  logic [CW-1:0] cntM;

  outs_t obA, obM;
  assign obA = {vA, cntA, pcA, rs1A, rs2A, rdA, immA, regWRA, memWRA, s1A, s2A, brA, jA, illA, wbA, aluA, bcA, mcA};
  assign obM = {vM, cntM, pcM, rs1M, rs2M, rdM, immM, regWRM, memWRM, s1M, s2M, brM, jM, illM, wbM, aluM, bcM, mcM};

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_MEXT(0), .CNT_W(CW)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(readyA), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .ex_load(ex_load), .ex_rd(ex_rd), .out_ready(out_ready), .out_valid(vA),
    .out_pc(pcA), .out_rs1(rs1A), .out_rs2(rs2A), .out_rd(rdA), .out_imm(immA),
    .out_regWR(regWRA), .out_memWR(memWRA), .out_aluS1(s1A), .out_aluS2(s2A),
    .out_doBranch(brA), .out_doJump(jA), .out_illegal(illA), .out_wbCtrl(wbA),
    .out_aluOp(aluA), .out_branchCtrl(bcA), .out_memCtrl(mcA), .hazard_cnt(cntA));

  decode_stage #(.XLEN(32), .EN_MEXT(1), .CNT_W(CW)) dutM (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(readyM), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .ex_load(ex_load), .ex_rd(ex_rd), .out_ready(out_ready), .out_valid(vM),
    .out_pc(pcM), .out_rs1(rs1M), .out_rs2(rs2M), .out_rd(rdM), .out_imm(immM),
    .out_regWR(regWRM), .out_memWR(memWRM), .out_aluS1(s1M), .out_aluS2(s2M),
    .out_doBranch(brM), .out_doJump(jM), .out_illegal(illM), .out_wbCtrl(wbM),
    .out_aluOp(aluM), .out_branchCtrl(bcM), .out_memCtrl(mcM), .hazard_cnt(cntM));

  int total = 0;
  int bad = 0;
  bit mValid;
  logic [CW-1:0] mCnt;
  dec_t mDecA, mDecM;
  logic lastReadyA, lastReadyM;
  logic [31:0] pcNext = 32'h0000_1000;
  vec_t vt[$];
  int opList[10] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h37, 'h17, 'h6F, 'h67, 'h0F};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encR(input int f7, input int r2, input int r1, input int f3, input int rd);
    return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] encI(input int imm, input int r1, input int f3, input int rd, input int op);
    return {12'(imm), 5'(r1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] encS(input int imm, input int r2, input int r1, input int f3);
    logic [11:0] s;
    s = 12'(imm);
    return {s[11:5], 5'(r2), 5'(r1), 3'(f3), s[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] encB(input int imm, input int r2, input int r1, input int f3);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(r2), 5'(r1), 3'(f3), b[4:1], b[11], 7'h63};
  endfunction
  function automatic logic [31:0] encU(input int imm20, input int rd, input int op);
    return {20'(imm20), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] encJ(input int imm, input int rd);
    logic [20:0] j;
    j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'h6F};
  endfunction

  // Returns {uses rs1, uses rs2} by instruction class.
  function automatic logic [1:0] usesRs(input logic [6:0] op);
    case (op)
      7'h33, 7'h23, 7'h63: return 2'b11;
      7'h13, 7'h03, 7'h67: return 2'b10;
      default:             return 2'b00;
    endcase
  endfunction

  function automatic dec_t refDecode(input logic [31:0] i, input logic [31:0] pc, input bit mext);
    dec_t d;
    int aluR[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int op = int'(i[6:0]);
    int f3 = int'(i[14:12]);
    int f7 = int'(i[31:25]);
    logic [31:0] immI, immS, immU;
    int immB, immJ;
    bit ill = 0;
    immI = $signed(i) >>> 20;
    immS = (immI & ~32'h1F) | {27'd0, i[11:7]};
    immU = i & 32'hFFFF_F000;
    immB = int'(i[30:25]) * 32 + int'(i[11:8]) * 2 + int'(i[7]) * 2048 - (i[31] ? 4096 : 0);
    immJ = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096 - (i[31] ? (1 << 20) : 0);
    d = '0;
    d.pc = pc; d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
    case (op)
      'h33: begin
        d.regWR = 1;
        if (f7 == 0) d.aluOp = 5'(aluR[f3]);
        else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) d.aluOp = 5'(aluR[f3] + 1);
        else if (f7 == 1 && mext) d.aluOp = 5'(16 + f3);
        else ill = 1;
      end
      'h13: begin
        d.regWR = 1; d.aluS2 = 1; d.imm = immI;
        d.aluOp = (f3 == 5 && f7 == 'h20) ? 5'd7 : 5'(aluR[f3]);
        ill = (f3 == 1 && f7 != 0);
      end
      'h03: begin
        d.regWR = 1; d.aluS2 = 1; d.wbCtrl = 1; d.imm = immI; d.memCtrl = 3'(f3);
        ill = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      'h23: begin
        d.memWR = 1; d.aluS2 = 1; d.imm = immS; d.memCtrl = 3'(f3);
        ill = (f3 >= 3);
      end
      'h63: begin
        d.doBranch = 1; d.aluS1 = 1; d.aluS2 = 1; d.imm = 32'(immB); d.branchCtrl = 3'(f3);
        ill = (f3 == 2 || f3 == 3);
      end
      'h37: begin d.regWR = 1; d.aluS2 = 1; d.aluOp = 10; d.imm = immU; end
      'h17: begin d.regWR = 1; d.aluS1 = 1; d.aluS2 = 1; d.imm = immU; end
      'h6F: begin
        d.regWR = 1; d.doJump = 1; d.aluS1 = 1; d.aluS2 = 1; d.wbCtrl = 2; d.imm = 32'(immJ);
      end
      'h67: begin
        d.regWR = 1; d.doJump = 1; d.aluS2 = 1; d.wbCtrl = 2; d.imm = immI;
        ill = (f3 != 0);
      end
      default: ill = 1;
    endcase
    if (ill) begin
      d.illegal = 1; d.regWR = 0; d.memWR = 0; d.doBranch = 0; d.doJump = 0;
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input outs_t a, input dec_t e);
    cmp({tag, ".valid"}, 32'(a.valid), 32'(mValid));
    cmp({tag, ".hazard_cnt"}, 32'(a.cnt), 32'(mCnt));
    if (mValid) begin
      cmp({tag, ".pc"}, a.d.pc, e.pc);
      cmp({tag, ".rs1"}, 32'(a.d.rs1), 32'(e.rs1));
      cmp({tag, ".rs2"}, 32'(a.d.rs2), 32'(e.rs2));
      cmp({tag, ".rd"}, 32'(a.d.rd), 32'(e.rd));
      cmp({tag, ".illegal"}, 32'(a.d.illegal), 32'(e.illegal));
      cmp({tag, ".regWR"}, 32'(a.d.regWR), 32'(e.regWR));
      cmp({tag, ".memWR"}, 32'(a.d.memWR), 32'(e.memWR));
      cmp({tag, ".doBranch"}, 32'(a.d.doBranch), 32'(e.doBranch));
      cmp({tag, ".doJump"}, 32'(a.d.doJump), 32'(e.doJump));
      if (!e.illegal) begin
        cmp({tag, ".imm"}, a.d.imm, e.imm);
        cmp({tag, ".aluS1"}, 32'(a.d.aluS1), 32'(e.aluS1));
        cmp({tag, ".aluS2"}, 32'(a.d.aluS2), 32'(e.aluS2));
        cmp({tag, ".wbCtrl"}, 32'(a.d.wbCtrl), 32'(e.wbCtrl));
        cmp({tag, ".aluOp"}, 32'(a.d.aluOp), 32'(e.aluOp));
        cmp({tag, ".branchCtrl"}, 32'(a.d.branchCtrl), 32'(e.branchCtrl));
        cmp({tag, ".memCtrl"}, 32'(a.d.memCtrl), 32'(e.memCtrl));
      end
    end
  endtask

  // One clock: in_ready and the model are evaluated mid-cycle, registered outputs just after the edge.
  task automatic stepCycle();
    logic [1:0] u;
    bit hz, adv, rdy;
    @(negedge clk);
    u   = usesRs(in_instr[6:0]);
    hz  = in_valid && ex_load && ex_rd != 0 &&
          ((u[1] && in_instr[19:15] == ex_rd) || (u[0] && in_instr[24:20] == ex_rd));
    adv = !mValid || out_ready;
    rdy = adv && !hz && !flush;
    lastReadyA = readyA;
    lastReadyM = readyM;
    cmp("in_ready.A", 32'(readyA), 32'(rdy));
    cmp("in_ready.M", 32'(readyM), 32'(rdy));
    if (flush) mValid = 0;
    else if (adv) begin
      if (hz && mCnt != '1) mCnt++;
      if (in_valid && rdy) begin
        mValid = 1;
        mDecA  = refDecode(in_instr, in_pc, 0);
        mDecM  = refDecode(in_instr, in_pc, 1);
      end else mValid = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("A", obA, mDecA);
    checkOutput("M", obM, mDecM);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic ordy,
                               input logic fl, input logic ld, input logic [4:0] erd);
    in_valid = v; in_instr = instr; out_ready = ordy; flush = fl; ex_load = ld; ex_rd = erd;
    in_pc = pcNext;
    pcNext += 4;
    stepCycle();
  endtask

  task automatic doReset();
    rst = 1; in_valid = 1; in_instr = 32'h002081B3; in_pc = 0;
    out_ready = 1; flush = 0; ex_load = 0; ex_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset.valid.A", 32'(vA), 0);
    cmp("reset.valid.M", 32'(vM), 0);
    cmp("reset.cnt.A", 32'(cntA), 0);
    cmp("reset.cnt.M", 32'(cntM), 0);
    cmp("reset.ready.A", 32'(readyA), 1);
    rst = 0; mValid = 0; mCnt = '0;
  endtask

  task automatic checkVec(input string tag, input outs_t a, input vec_t v, input logic ill);
    cmp({tag, ".vec.illegal"}, 32'(a.d.illegal), 32'(ill));
    cmp({tag, ".vec.regWR"}, 32'(a.d.regWR), 32'(v.regWR & ~ill));
    cmp({tag, ".vec.memWR"}, 32'(a.d.memWR), 32'(v.memWR & ~ill));
    cmp({tag, ".vec.doBranch"}, 32'(a.d.doBranch), 32'(v.br & ~ill));
    cmp({tag, ".vec.doJump"}, 32'(a.d.doJump), 32'(v.jmp & ~ill));
    if (!ill) begin
      cmp({tag, ".vec.imm"}, a.d.imm, v.imm);
      cmp({tag, ".vec.aluOp"}, 32'(a.d.aluOp), 32'(v.aluOp));
      cmp({tag, ".vec.aluS1"}, 32'(a.d.aluS1), 32'(v.s1));
      cmp({tag, ".vec.aluS2"}, 32'(a.d.aluS2), 32'(v.s2));
      cmp({tag, ".vec.wbCtrl"}, 32'(a.d.wbCtrl), 32'(v.wb));
      cmp({tag, ".vec.memCtrl"}, 32'(a.d.memCtrl), 32'(v.mc));
      cmp({tag, ".vec.branchCtrl"}, 32'(a.d.branchCtrl), 32'(v.bc));
    end
  endtask

  initial begin
    logic [31:0] addI, subI, addiI, luiI, luseI;
    addI  = 32'h002081B3;
    subI  = 32'h402081B3;
    addiI = encI(-1, 0, 0, 1, 'h13);
    luiI  = encU('h12345, 7, 'h37);
    luseI = encR(0, 4, 3, 0, 5);

    vt.push_back('{addI,                    32'h0,          0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{subI,                    32'h0,          1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encR('h20, 2, 1, 5, 3),  32'h0,          7,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encR(0, 2, 1, 6, 3),     32'h0,          8,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encR(0, 2, 1, 3, 3),     32'h0,          4,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encR('h20, 2, 1, 1, 3),  32'h0,          0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1});
    vt.push_back('{32'h02208033,            32'h0,          16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{encR(1, 2, 1, 7, 3),     32'h0,          23, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{addiI,                   32'hFFFFFFFF,   0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encI('h403, 2, 5, 1, 'h13), 32'h403,     7,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encI(5, 2, 3, 1, 'h13),  32'h5,          4,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encI('h021, 2, 1, 1, 'h13), 32'h21,      2,  1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1});
    vt.push_back('{encI(-4, 2, 2, 5, 'h03), 32'hFFFFFFFC,   0,  1, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0});
    vt.push_back('{encI(16, 2, 5, 5, 'h03), 32'h10,         0,  1, 0, 0, 1, 0, 0, 1, 5, 0, 0, 0});
    vt.push_back('{encI(16, 2, 3, 5, 'h03), 32'h10,         0,  1, 0, 0, 1, 0, 0, 1, 3, 0, 1, 1});
    vt.push_back('{encS(8, 5, 2, 2),        32'h8,          0,  0, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0});
    vt.push_back('{encS(-32, 5, 2, 0),      32'hFFFFFFE0,   0,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encS(8, 5, 2, 3),        32'h8,          0,  0, 1, 0, 1, 0, 0, 0, 3, 0, 1, 1});
    vt.push_back('{encB(-8, 2, 1, 0),       32'hFFFFFFF8,   0,  0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encB(4094, 2, 1, 7),     32'h00000FFE,   0,  0, 0, 1, 1, 1, 0, 0, 0, 7, 0, 0});
    vt.push_back('{encB(8, 2, 1, 2),        32'h8,          0,  0, 0, 1, 1, 1, 0, 0, 0, 2, 1, 1});
    vt.push_back('{luiI,                    32'h12345000,   10, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{32'h00001097,            32'h00001000,   0,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{encJ(-2, 1),             32'hFFFFFFFE,   0,  1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0});
    vt.push_back('{encJ('hFFFFE, 1),        32'h000FFFFE,   0,  1, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0});
    vt.push_back('{32'h000080E7,            32'h0,          0,  1, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0});
    vt.push_back('{encI(4, 1, 1, 1, 'h67),  32'h4,          0,  1, 0, 0, 1, 0, 1, 2, 0, 0, 1, 1});
    vt.push_back('{32'h0000001F,            32'h0,          0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1});

    doReset();

    for (int k = 0; k < vt.size(); k++) begin
      applyStimulus(1, vt[k].instr, 1, 0, 0, 0);
      cmp("vec.valid", 32'(vA), 1);
      checkVec("A", obA, vt[k], vt[k].illA);
      checkVec("M", obM, vt[k], vt[k].illM);
    end

    applyStimulus(1, addI, 1, 0, 0, 0);
    cmp("stream.add.aluOp", 32'(aluA), 0);
    applyStimulus(1, subI, 1, 0, 0, 0);
    cmp("stream.sub.valid", 32'(vA), 1);
    cmp("stream.sub.aluOp", 32'(aluA), 1);
    cmp("stream.sub.regWR", 32'(regWRA), 1);

    applyStimulus(1, addiI, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, luiI, 0, 0, 0, 0);
      cmp("bp.in_ready", 32'(lastReadyA), 0);
      cmp("bp.hold.valid", 32'(vA), 1);
      cmp("bp.hold.imm", immA, 32'hFFFFFFFF);
    end
    applyStimulus(1, luiI, 1, 0, 0, 0);
    cmp("bp.release.ready", 32'(lastReadyA), 1);
    cmp("bp.release.aluOp", 32'(aluA), 10);
    cmp("bp.release.imm", immA, 32'h12345000);

    doReset();
    applyStimulus(1, luseI, 1, 0, 1, 3);
    cmp("lu.rs1.ready", 32'(lastReadyA), 0);
    cmp("lu.rs1.bubble", 32'(vA), 0);
    cmp("lu.rs1.cnt", 32'(cntA), 1);
    applyStimulus(1, luseI, 1, 0, 1, 0);
    cmp("lu.x0.ready", 32'(lastReadyA), 1);
    cmp("lu.x0.valid", 32'(vA), 1);
    cmp("lu.x0.cnt", 32'(cntA), 1);
    applyStimulus(1, luseI, 1, 0, 1, 4);
    cmp("lu.rs2.bubble", 32'(vA), 0);
    cmp("lu.rs2.cnt", 32'(cntM), 2);

    applyStimulus(1, addI, 1, 0, 0, 0);
    applyStimulus(1, luseI, 1, 1, 1, 3);
    cmp("flush.ready", 32'(lastReadyA), 0);
    cmp("flush.valid", 32'(vA), 0);
    cmp("flush.hazard.cnt", 32'(cntA), 2);
    applyStimulus(1, addI, 1, 0, 0, 0);
    applyStimulus(1, addI, 0, 1, 0, 0);
    cmp("flush.hold.valid", 32'(vA), 0);

    applyStimulus(1, addI, 1, 0, 0, 0);
    applyStimulus(1, luseI, 0, 0, 1, 3);
    cmp("hold.hazard.cnt", 32'(cntA), 2);
    cmp("hold.hazard.valid", 32'(vA), 1);
    repeat (20) applyStimulus(1, luseI, 1, 0, 1, 3);
    cmp("sat.cnt.A", 32'(cntA), 15);
    cmp("sat.cnt.M", 32'(cntM), 15);

    doReset();
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'(opList[$urandom_range(0, 9)]);
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)));
    end
    cmp("rand.ready.agree", 32'(lastReadyM), 32'(lastReadyA));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
